moka_rv32i_trace_buffer: RTL and testbench

Parametrised retire-trace capture buffer for the pipelined RV32I core. It sits beside the writeback stage. It records one entry per retired instruction (PC, instruction word, destination register, write enable, result) into a DEPTH-entry circular store. Three capture modes are supported: continuous wrap, stop-when-full, and PC-triggered pre/post capture. Entries are read out oldest-first over a valid/ready port, so a debug bench or a debug module can inspect pipeline history without widening the core's internal signal bundle.

---
 rtl/moka_rv32i_trace_buffer_if.sv | 43 ++++
 rtl/moka_rv32i_trace_buffer.sv | 112 +++++++++++
 tb/tb_moka_rv32i_trace_buffer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/moka_rv32i_trace_buffer_if.sv
// Bundles the control, retire and read-out signals of the retire-trace buffer.
// The master drives capture control, retire records and rd_ready. The slave is the buffer itself.
interface moka_rv32i_trace_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  logic                        en;
  logic                        clear;
  logic [1:0]                  mode;
  logic [DATA_WIDTH-1:0]       trig_pc;
  logic                        ret_valid;
  logic [DATA_WIDTH-1:0]       ret_pc;
  logic [DATA_WIDTH-1:0]       ret_instr;
  logic [DATA_WIDTH-1:0]       ret_result;
  logic [4:0]                  ret_rd;
  logic                        ret_regwrite;
  logic                        rd_valid;
  logic                        rd_ready;
  logic [DATA_WIDTH-1:0]       rd_pc;
  logic [DATA_WIDTH-1:0]       rd_instr;
  logic [DATA_WIDTH-1:0]       rd_result;
  logic [4:0]                  rd_rd;
  logic                        rd_regwrite;
  logic [$clog2(DEPTH):0]      count;
  logic                        full;
  logic                        overflow;
  logic                        triggered;
  logic                        frozen;

  modport master (
    output en, clear, mode, trig_pc, ret_valid, ret_pc, ret_instr, ret_result,
           ret_rd, ret_regwrite, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_result, rd_rd, rd_regwrite,
           count, full, overflow, triggered, frozen
  );

  modport slave (
    input  en, clear, mode, trig_pc, ret_valid, ret_pc, ret_instr, ret_result,
           ret_rd, ret_regwrite, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_result, rd_rd, rd_regwrite,
           count, full, overflow, triggered, frozen
  );
endinterface

// File: rtl/moka_rv32i_trace_buffer.sv
// Retire-trace capture buffer. It stores one record per retired instruction in a circular store.
// Three capture modes: continuous wrap, stop-when-full, and PC-triggered pre/post capture. Read-out is oldest-first.
module moka_rv32i_trace_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int POST_TRIG  = 4
) (
  input  logic clk,
  input  logic rst,
  moka_rv32i_trace_buffer_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int REC = 3 * DATA_WIDTH + 6;

  typedef enum logic [1:0] {RUN, POST, FROZEN} stateT;

  stateT             state;
  logic [REC-1:0]    mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [CW-1:0]     countReg;
  logic [CW-1:0]     postCnt;
  logic              overflowReg;
  logic              triggeredReg;
  logic              frozenReg;
  logic [REC-1:0]    head;

  logic isFull, push, pop, drop, store, overwrite, modeStop, modeTrig, trigHit;

  assign isFull    = (countReg == CW'(DEPTH));
  assign modeStop  = (bus.mode == 2'b01);
  assign modeTrig  = (bus.mode == 2'b10);
  assign push      = bus.en && bus.ret_valid && (state != FROZEN);
  assign pop       = (countReg != '0) && bus.rd_ready;
  // Only stop-when-full refuses a record; every other mode overwrites the oldest entry.
  assign drop      = push && isFull && !pop && modeStop && (state == RUN);
  assign store     = push && !drop;
  assign overwrite = store && isFull && !pop;
  assign trigHit   = store && modeTrig && (bus.ret_pc == bus.trig_pc);

  always_ff @(posedge clk) begin
    if (store && !bus.clear)
      mem[wp] <= {bus.ret_pc, bus.ret_instr, bus.ret_result, bus.ret_rd, bus.ret_regwrite};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.clear) begin
      wp           <= '0;
      rp           <= '0;
      countReg     <= '0;
      postCnt      <= '0;
      overflowReg  <= 1'b0;
      triggeredReg <= 1'b0;
      frozenReg    <= 1'b0;
      state        <= RUN;
    end else begin
      if (store)
        wp <= wp + 1'b1;
      if (overwrite || pop)
        rp <= rp + 1'b1;
      if (store && !pop && !isFull)
        countReg <= countReg + CW'(1);
      else if (pop && !store)
        countReg <= countReg - CW'(1);
      if (overwrite || drop)
        overflowReg <= 1'b1;

      case (state)
        RUN: begin
          if (drop) begin
            state     <= FROZEN;
            frozenReg <= 1'b1;
          end else if (trigHit) begin
            triggeredReg <= 1'b1;
            if (POST_TRIG == 0) begin
              state     <= FROZEN;
              frozenReg <= 1'b1;
            end else begin
              state   <= POST;
              postCnt <= CW'(POST_TRIG);
            end
          end
        end
        POST: begin
          if (store) begin
            postCnt <= postCnt - CW'(1);
            if (postCnt == CW'(1)) begin
              state     <= FROZEN;
              frozenReg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The head entry is driven straight from the array, so a pop shows the next entry one cycle later.
  assign head            = mem[rp];
  assign bus.rd_pc       = head[REC-1 -: DATA_WIDTH];
  assign bus.rd_instr    = head[2*DATA_WIDTH+5 -: DATA_WIDTH];
  assign bus.rd_result   = head[DATA_WIDTH+5 -: DATA_WIDTH];
  assign bus.rd_rd       = head[5:1];
  assign bus.rd_regwrite = head[0];
  assign bus.rd_valid    = (countReg != '0);
  assign bus.count       = countReg;
  assign bus.full        = isFull;
  assign bus.overflow    = overflowReg;
  assign bus.triggered   = triggeredReg;
  assign bus.frozen      = frozenReg;
endmodule

// File: tb/tb_moka_rv32i_trace_buffer.sv
// Self-checking bench for the retire-trace buffer. A queue-based reference model is checked every cycle.
// A second instance with POST_TRIG=0 covers the case where capture freezes on the trigger record.
module tb_moka_rv32i_trace_buffer;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int PT    = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
  } recT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  moka_rv32i_trace_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) aIf ();
  moka_rv32i_trace_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bIf ();

  moka_rv32i_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .POST_TRIG(PT)) dut (
    .clk(clk), .rst(rst), .bus(aIf.slave));
  moka_rv32i_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .POST_TRIG(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bIf.slave));

  always #5 clk = ~clk;

  // Reference model: an ordered queue of held records plus the sticky flags.
  recT         q[$];
  bit          mOvf, mTrig, mFrz, mInPost;
  int          mPostLeft;
  logic [1:0]  curMode;
  logic [31:0] curTrig;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    q.delete();
    mOvf = 0; mTrig = 0; mFrz = 0; mInPost = 0; mPostLeft = 0;
  endfunction

  function automatic void modelStep(bit clr, bit e, bit v, recT r, bit rdy);
    bit stored;
    if (clr) begin
      modelReset();
      return;
    end
    stored = 0;
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (e && v && !mFrz) begin
      if (q.size() == DEPTH) begin
        if (curMode == 2'b01 && !mInPost) begin
          mOvf = 1;
          mFrz = 1;
        end else begin
          void'(q.pop_front());
          q.push_back(r);
          mOvf = 1;
          stored = 1;
        end
      end else begin
        q.push_back(r);
        stored = 1;
      end
    end
    if (stored) begin
      if (mInPost) begin
        mPostLeft--;
        if (mPostLeft == 0) begin
          mInPost = 0;
          mFrz = 1;
        end
      end else if (curMode == 2'b10 && r.pc == curTrig) begin
        mTrig = 1;
        mInPost = 1;
        mPostLeft = PT;
      end
    end
  endfunction

  task automatic chkStatus();
    chk("count", aIf.count, q.size());
    chk("full", aIf.full, q.size() == DEPTH);
    chk("overflow", aIf.overflow, mOvf);
    chk("triggered", aIf.triggered, mTrig);
    chk("frozen", aIf.frozen, mFrz);
  endtask

  // One clock: drive at posedge+1, check the head, step the model at the edge, then check status.
  task automatic cyc(input bit e, input bit v, input logic [31:0] pc, input bit rdy, input bit clr);
    recT r;
    r.pc = pc; r.instr = $urandom; r.result = $urandom;
    r.rd = 5'($urandom); r.rw = 1'($urandom);
    aIf.en = e; aIf.ret_valid = v; aIf.ret_pc = r.pc; aIf.ret_instr = r.instr;
    aIf.ret_result = r.result; aIf.ret_rd = r.rd; aIf.ret_regwrite = r.rw;
    aIf.rd_ready = rdy; aIf.clear = clr; aIf.mode = curMode; aIf.trig_pc = curTrig;
    #0;
    chk("rd_valid", aIf.rd_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("rd_pc", aIf.rd_pc, q[0].pc);
      chk("rd_instr", aIf.rd_instr, q[0].instr);
      chk("rd_result", aIf.rd_result, q[0].result);
      chk("rd_rd", aIf.rd_rd, q[0].rd);
      chk("rd_regwrite", aIf.rd_regwrite, q[0].rw);
    end
    @(posedge clk);
    modelStep(clr, e, v, r, rdy);
    #1;
    chkStatus();
  endtask

  task automatic clearTo(input logic [1:0] md, input logic [31:0] tpc);
    curMode = md;
    curTrig = tpc;
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic bStep(input bit v, input logic [31:0] pc, input bit rdy, input bit clr);
    bIf.en = 1; bIf.ret_valid = v; bIf.ret_pc = pc; bIf.rd_ready = rdy; bIf.clear = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    curMode = 0; curTrig = 0;
    aIf.en = 0; aIf.clear = 0; aIf.mode = 0; aIf.trig_pc = 0; aIf.ret_valid = 0;
    aIf.ret_pc = 0; aIf.ret_instr = 0; aIf.ret_result = 0; aIf.ret_rd = 0;
    aIf.ret_regwrite = 0; aIf.rd_ready = 0;
    bIf.en = 0; bIf.clear = 0; bIf.mode = 2'b10; bIf.trig_pc = 32'h100; bIf.ret_valid = 0;
    bIf.ret_pc = 0; bIf.ret_instr = 32'h13; bIf.ret_result = 0; bIf.ret_rd = 0;
    bIf.ret_regwrite = 0; bIf.rd_ready = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", aIf.count, 0);
    chk("rst_rd_valid", aIf.rd_valid, 0);
    chk("rst_full", aIf.full, 0);
    chk("rst_overflow", aIf.overflow, 0);
    chk("rst_triggered", aIf.triggered, 0);
    chk("rst_frozen", aIf.frozen, 0);
    rst = 1'b0;

    // Mode 00: 20 pushes wrap over the first four, then pop oldest-first.
    clearTo(2'b00, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, 32'(4 * i), 0, 0);
    chk("m0_count", aIf.count, 16);
    chk("m0_overflow", aIf.overflow, 1);
    for (int i = 0; i < 16; i++) begin
      #0;
      chk("m0_pop_pc", aIf.rd_pc, 32'(32'h10 + 4 * i));
      cyc(0, 0, 0, 1, 0);
    end
    chk("m0_empty", aIf.rd_valid, 0);

    // Mode 01: the 17th record is dropped and capture freezes.
    clearTo(2'b01, 0);
    for (int i = 0; i < 17; i++) cyc(1, 1, 32'(4 * i), 0, 0);
    chk("m1_count", aIf.count, 16);
    chk("m1_frozen", aIf.frozen, 1);
    chk("m1_overflow", aIf.overflow, 1);
    cyc(1, 1, 32'h200, 0, 0);
    chk("m1_head", aIf.rd_pc, 0);
    clearTo(2'b01, 0);
    chk("m1_clr_count", aIf.count, 0);
    chk("m1_clr_frozen", aIf.frozen, 0);

    // Mode 10 with four post-trigger records.
    clearTo(2'b10, 32'h100);
    for (int i = 0; i < 13; i++) cyc(1, 1, 32'(32'hF0 + 4 * i), 0, 0);
    chk("m2_count", aIf.count, 9);
    chk("m2_triggered", aIf.triggered, 1);
    chk("m2_frozen", aIf.frozen, 1);
    for (int i = 0; i < 9; i++) begin
      #0;
      chk("m2_pop_pc", aIf.rd_pc, 32'(32'hF0 + 4 * i));
      cyc(0, 0, 0, 1, 0);
    end

    // Full buffer with a push and a pop every cycle: plain writes, no overflow.
    clearTo(2'b00, 0);
    for (int i = 0; i < 16; i++) cyc(1, 1, 32'(32'h400 + 4 * i), 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 32'(32'h500 + 4 * i), 1, 0);
    chk("pp_count", aIf.count, 16);
    chk("pp_overflow", aIf.overflow, 0);

    // Asynchronous reset in the middle of the post-trigger window.
    clearTo(2'b10, 32'h100);
    cyc(1, 1, 32'h100, 0, 0);
    cyc(1, 1, 32'h104, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    chk("ar_count", aIf.count, 0);
    chk("ar_rd_valid", aIf.rd_valid, 0);
    chk("ar_triggered", aIf.triggered, 0);
    chk("ar_frozen", aIf.frozen, 0);
    chk("ar_overflow", aIf.overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1, 1, 32'(32'h100 + 4 * i), 0, 0);
    chk("ar_rerun_frozen", aIf.frozen, 1);
    chk("ar_rerun_count", aIf.count, 5);

    // Randomized traffic across all modes; PCs collide with trig_pc now and then.
    for (int round = 0; round < 6; round++) begin
      clearTo(2'($urandom_range(0, 3)), 32'h40);
      for (int i = 0; i < 70; i++)
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
            32'(4 * $urandom_range(0, 31)), $urandom_range(0, 9) < 4, 0);
    end

    // POST_TRIG=0 instance: the trigger record is the last one stored.
    bStep(0, 0, 0, 1);
    bStep(1, 32'hF8, 0, 0);
    bStep(1, 32'hFC, 0, 0);
    chk("pt0_pre_frozen", bIf.frozen, 0);
    bStep(1, 32'h100, 0, 0);
    chk("pt0_frozen", bIf.frozen, 1);
    chk("pt0_triggered", bIf.triggered, 1);
    bStep(1, 32'h104, 0, 0);
    chk("pt0_count", bIf.count, 3);
    bStep(0, 0, 1, 0);
    bStep(0, 0, 1, 0);
    bIf.rd_ready = 0;
    chk("pt0_last_pc", bIf.rd_pc, 32'h100);
    chk("pt0_last_count", bIf.count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
